// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl: sequencing controller for the data-cache tag SRAM.
// Owns the per-set valid bits, runs hit/miss lookups, requests refills,
// writes the refilled tag, and performs a set-by-set flush walk.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   lk_req_i, lk_addr_i           lookup request (level) and address
//   lk_gnt_o                      lookup accepted this cycle
//   lk_done_o, lk_hit_o           lookup result pulse and hit flag
//   miss_req_o, miss_addr_o       refill request and line-aligned address
//   fill_done_i                   refill complete pulse
//   flush_req_i, flush_busy_o     invalidate-all request, walk in progress
//   ta_CS_o/OE_o/WEB_o/A_o/DI_o   tag SRAM controls and write data
//   ta_DO_i                       tag SRAM read data (one cycle after read)
`timescale 1ns/1ps
module tag_array_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned OFF_W  = 4,
    parameter int unsigned TAG_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_req_i,
    input  logic [ADDR_W-1:0] lk_addr_i,
    output logic              lk_gnt_o,
    output logic              lk_done_o,
    output logic              lk_hit_o,
    output logic              miss_req_o,
    output logic [ADDR_W-1:0] miss_addr_o,
    input  logic              fill_done_i,
    input  logic              flush_req_i,
    output logic              flush_busy_o,
    output logic              ta_CS_o,
    output logic              ta_OE_o,
    output logic              ta_WEB_o,
    output logic [IDX_W-1:0]  ta_A_o,
    output logic [TAG_W-1:0]  ta_DI_o,
    input  logic [TAG_W-1:0]  ta_DO_i
);

    localparam int unsigned SETS   = 1 << IDX_W;
    localparam int unsigned LINE_W = IDX_W + TAG_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [SETS-1:0]   valid_q;
    logic              flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              valid_set_c, valid_clr_c;
    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;

    // Line offset bits never matter to the tag array.
    logic unused_offset;
    assign unused_offset = ^lk_addr_i[OFF_W-1:0];

    assign idx_q       = line_q[IDX_W-1:0];
    assign tag_q       = line_q[LINE_W-1:IDX_W];
    assign miss_addr_o = {line_q, {OFF_W{1'b0}}};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    // Per-set valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (valid_set_c) begin
            valid_q[idx_q] <= 1'b1;
        end else if (valid_clr_c) begin
            valid_q[cnt_q] <= 1'b0;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        valid_set_c  = 1'b0;
        valid_clr_c  = 1'b0;
        lk_gnt_o     = 1'b0;
        lk_done_o    = 1'b0;
        lk_hit_o     = 1'b0;
        miss_req_o   = 1'b0;
        flush_busy_o = 1'b0;
        ta_CS_o      = 1'b0;
        ta_OE_o      = 1'b0;
        ta_WEB_o     = 1'b1;
        ta_A_o       = '0;
        ta_DI_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (flush_pend_q || flush_req_i) begin
                    state_d = S_FLUSH;
                end else if (lk_req_i && !rst) begin
                    // Gated by rst so the grant path is quiet during reset.
                    lk_gnt_o = 1'b1;
                    line_d   = lk_addr_i[ADDR_W-1:OFF_W];
                    ta_CS_o  = 1'b1;
                    ta_OE_o  = 1'b1;
                    ta_A_o   = lk_addr_i[OFF_W +: IDX_W];
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_done_o = 1'b1;
                lk_hit_o  = valid_q[idx_q] && (ta_DO_i == tag_q);
                state_d   = lk_hit_o ? S_IDLE : S_MISS;
                if (flush_req_i) flush_pend_d = 1'b1;
            end
            S_MISS: begin
                miss_req_o = 1'b1;
                if (flush_req_i) flush_pend_d = 1'b1;
                if (fill_done_i) state_d = S_FILL;
            end
            S_FILL: begin
                ta_CS_o     = 1'b1;
                ta_WEB_o    = 1'b0;
                ta_A_o      = idx_q;
                ta_DI_o     = tag_q;
                valid_set_c = 1'b1;
                if (flush_req_i) flush_pend_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_FLUSH: begin
                flush_busy_o = 1'b1;
                ta_CS_o      = 1'b1;
                ta_WEB_o     = 1'b0;
                ta_A_o       = cnt_q;
                valid_clr_c  = 1'b1;
                cnt_d        = IDX_W'(cnt_q + 1'b1);
                // Requests arriving mid-walk are absorbed by this clear.
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    flush_pend_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
